bsg_manycore_boot_sequencer: RTL

//   Sequences SPMD testbench bring-up and run:

---
 rtl/bsg_manycore_boot_seq_pkg.sv | 31 +++
 rtl/bsg_manycore_boot_seq_sat_ctr.sv | 25 ++
 rtl/bsg_manycore_boot_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/bsg_manycore_boot_seq_pkg.sv
// Purpose: shared state encoding and helpers for the manycore boot sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bsg_manycore_boot_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_WAITTAG = 3'd1,
        ST_RELEASE = 3'd2,
        ST_LOAD    = 3'd3,
        ST_RUN     = 3'd4,
        ST_DONE    = 3'd5,
        ST_FAIL    = 3'd6,
        ST_TIMEOUT = 3'd7
    } bsg_boot_seq_state_e;

    localparam logic [2:0] state_hold_c    = 3'd0;
    localparam logic [2:0] state_waittag_c = 3'd1;
    localparam logic [2:0] state_release_c = 3'd2;
    localparam logic [2:0] state_load_c    = 3'd3;
    localparam logic [2:0] state_run_c     = 3'd4;
    localparam logic [2:0] state_done_c    = 3'd5;
    localparam logic [2:0] state_fail_c    = 3'd6;
    localparam logic [2:0] state_timeout_c = 3'd7;

    // IO complex is held in reset until the staged release completes.
    function automatic logic holds_io_reset(input bsg_boot_seq_state_e st);
        return (st == ST_HOLD) || (st == ST_WAITTAG) || (st == ST_RELEASE);
    endfunction

endpackage

// File: rtl/bsg_manycore_boot_seq_sat_ctr.sv
// Purpose: clear/enable up-counter that sticks at all-ones instead of wrapping.
// Latency: count reflects clear/en one cycle after they are sampled.
// Backpressure: none; clear has priority over en.
module bsg_manycore_boot_seq_sat_ctr #(
    parameter int width_p = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               en,
    output logic [width_p-1:0] count
);

    // Count up while enabled, holding at the maximum value once reached.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != {width_p{1'b1}})) begin
            count <= count + width_p'(1);
        end
    end

endmodule

// File: rtl/bsg_manycore_boot_sequencer.sv
// Purpose: sequences SPMD bring-up: hold, tag wait, staged IO reset release, load, run, terminal.
// Latency: all outputs registered, one cycle from input sample to output change.
// Backpressure: none; level/pulse inputs only. Optional watchdog under BSG_BOOT_SEQ_WATCHDOG_EN.
module bsg_manycore_boot_sequencer
    import bsg_manycore_boot_seq_pkg::*;
#(
    parameter int reset_depth_p    = 3,
    parameter int num_finish_p     = 1,
    parameter int timeout_cycles_p = 1000000,
    parameter int ctr_width_p      = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   tag_done_i,
    input  logic                   loader_done_i,
    input  logic                   finish_v_i,
    input  logic                   fail_v_i,
    output logic                   io_reset_o,
    output logic                   run_o,
    output logic                   done_o,
    output logic                   fail_o,
    output logic                   timeout_o,
    output logic [2:0]             state_o,
    output logic [ctr_width_p-1:0] run_cycles_o
);

    localparam int rel_w = (reset_depth_p < 2) ? 1 : $clog2(reset_depth_p);
    localparam int fin_w = $clog2(num_finish_p + 1);

    if (reset_depth_p < 1) begin : g_bad_depth
        $error("reset_depth_p must be >= 1");
    end
    if (num_finish_p < 1) begin : g_bad_finish
        $error("num_finish_p must be >= 1");
    end
    if (timeout_cycles_p < 1) begin : g_bad_timeout
        $error("timeout_cycles_p must be >= 1");
    end

    bsg_boot_seq_state_e state, state_next;
    logic [rel_w-1:0]    rel_cnt, rel_next;
    logic [fin_w-1:0]    fin_cnt, fin_next;
    logic                wd_expired;
    logic                io_reset_q, run_q, done_q, fail_q;

`ifdef BSG_BOOT_SEQ_WATCHDOG_EN
    logic [ctr_width_p-1:0] wd_cnt;
    logic                   timeout_q;

    // Watchdog accumulates LOAD+RUN time and is only ever cleared by reset.
    bsg_manycore_boot_seq_sat_ctr #(.width_p(ctr_width_p)) wd_ctr (
        .clk     (clk_i),
        .reset_n (reset_n_i),
        .clear   (1'b0),
        .en      ((state == ST_LOAD) || (state == ST_RUN)),
        .count   (wd_cnt)
    );

    // Current cycle is the last allowed one in LOAD+RUN.
    assign wd_expired = (wd_cnt == ctr_width_p'(timeout_cycles_p - 1));

    // Sticky timeout flag follows entry into the TIMEOUT state.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) timeout_q <= 1'b0;
        else            timeout_q <= (state_next == ST_TIMEOUT);
    end

    assign timeout_o = timeout_q;
`else
    assign wd_expired = 1'b0;
    assign timeout_o  = 1'b0;
`endif

    // Run-cycle counter restarts on every pass through LOAD and freezes outside RUN.
    bsg_manycore_boot_seq_sat_ctr #(.width_p(ctr_width_p)) run_ctr (
        .clk     (clk_i),
        .reset_n (reset_n_i),
        .clear   (state == ST_LOAD),
        .en      (state == ST_RUN),
        .count   (run_cycles_o)
    );

    // Next-state and inline counter updates; priority fail > done > timeout.
    always_comb begin
        state_next = state;
        rel_next   = rel_cnt;
        fin_next   = fin_cnt;
        case (state)
            ST_HOLD: state_next = ST_WAITTAG;
            ST_WAITTAG: begin
                if (tag_done_i) begin
                    state_next = ST_RELEASE;
                    rel_next   = rel_w'(reset_depth_p - 1);
                end
            end
            ST_RELEASE: begin
                if (!tag_done_i)           state_next = ST_WAITTAG;
                else if (rel_cnt == '0)    state_next = ST_LOAD;
                else                       rel_next   = rel_cnt - rel_w'(1);
            end
            ST_LOAD: begin
                if (fail_v_i)           state_next = ST_FAIL;
                else if (wd_expired)    state_next = ST_TIMEOUT;
                else if (loader_done_i) begin
                    state_next = ST_RUN;
                    fin_next   = '0;
                end
            end
            ST_RUN: begin
                if (fail_v_i) begin
                    state_next = ST_FAIL;
                end else if (finish_v_i && ((fin_cnt + fin_w'(1)) == fin_w'(num_finish_p))) begin
                    state_next = ST_DONE;
                    fin_next   = fin_cnt + fin_w'(1);
                end else begin
                    if (finish_v_i) fin_next = fin_cnt + fin_w'(1);
                    if (wd_expired) state_next = ST_TIMEOUT;
                end
            end
            default: state_next = state;
        endcase
    end

    // State, inline counters and registered flags derived from the next state.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state      <= ST_HOLD;
            rel_cnt    <= '0;
            fin_cnt    <= '0;
            io_reset_q <= 1'b1;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state      <= state_next;
            rel_cnt    <= rel_next;
            fin_cnt    <= fin_next;
            io_reset_q <= holds_io_reset(state_next);
            run_q      <= (state_next == ST_RUN);
            done_q     <= (state_next == ST_DONE);
            fail_q     <= (state_next == ST_FAIL);
        end
    end

    assign io_reset_o = io_reset_q;
    assign run_o      = run_q;
    assign done_o     = done_q;
    assign fail_o     = fail_q;
    assign state_o    = state;

endmodule
